// File: rtl/divn_pkg.sv
// ============================================================================
// divn_pkg : shared types and constants for the streaming divisibility checker
// Rev 1.0
// ============================================================================
`default_nettype none

package divn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam int DEF_MAX_MOD = 15;
    localparam int DEF_DIGIT_W = 2;

    function automatic int mod_width(input int max_mod);
        return $clog2(max_mod + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/divisible_n_stream_mod_step.sv
// ============================================================================
// mod_step : appends one DIGIT_W-bit digit to a remainder, (r*2^DIGIT_W+d) mod m
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_step
    import divn_pkg::*;
#(
    parameter int MW      = 4,
    parameter int DIGIT_W = DEF_DIGIT_W
) (
    input  logic [MW-1:0]      r,
    input  logic [DIGIT_W-1:0] d,
    input  logic [MW-1:0]      m,
    output logic [MW-1:0]      r_next
);

    // r < m keeps every 2r+b below 2m, so one conditional subtract per bit suffices
    logic [MW:0] acc [DIGIT_W+1];

    assign acc[0] = {1'b0, r};

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_bit
        logic [MW:0] w_t;
        assign w_t        = {acc[i][MW-1:0], d[DIGIT_W-1-i]};
        assign acc[i+1]   = (w_t >= {1'b0, m}) ? (w_t - {1'b0, m}) : w_t;
    end

    assign r_next = acc[DIGIT_W][MW-1:0];

endmodule

`default_nettype wire

// File: rtl/divisible_n_stream.sv
// ============================================================================
// divisible_n_stream : digit-serial divisibility checker with runtime modulus
// Rev 1.0
// ============================================================================
`default_nettype none

module divisible_n_stream
    import divn_pkg::*;
#(
    parameter int  MAX_MOD = DEF_MAX_MOD,
    parameter int  DIGIT_W = DEF_DIGIT_W,
    parameter int  CNT_W   = 16,
    localparam int MW      = mod_width(MAX_MOD)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [MW-1:0]      mod_in,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] in_data,
    output logic               out,
    output logic [MW-1:0]      rem,
    output logic               out_valid,
    output logic [CNT_W-1:0]   digits,
    output logic               err
);

    state_e           state_q, state_d;
    logic [MW-1:0]    mod_q, mod_d;
    logic [MW-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0] digits_q, digits_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    logic             mod_legal;
    logic [MW-1:0]    step_r, step_m, step_next;

    assign mod_legal = (mod_in != '0) && (int'(mod_in) <= MAX_MOD);

    // On clr the digit (if any) starts a fresh number under the new modulus
    assign step_r = clr ? '0     : rem_q;
    assign step_m = clr ? mod_in : mod_q;

    mod_step #(
        .MW      (MW),
        .DIGIT_W (DIGIT_W)
    ) u_mod_step (
        .r      (step_r),
        .d      (in_data),
        .m      (step_m),
        .r_next (step_next)
    );

    always_comb begin
        state_d     = state_q;
        mod_d       = mod_q;
        rem_d       = rem_q;
        digits_d    = digits_q;
        err_d       = err_q;
        out_valid_d = 1'b0;

        if (clr) begin
            if (mod_legal) begin
                state_d     = ST_RUN;
                mod_d       = mod_in;
                err_d       = 1'b0;
                rem_d       = in_valid ? step_next : '0;
                digits_d    = in_valid ? CNT_W'(1) : '0;
                out_valid_d = in_valid;
            end else begin
                state_d  = ST_ERR;
                mod_d    = '0;
                rem_d    = '0;
                digits_d = '0;
                err_d    = 1'b1;
            end
        end else if ((state_q == ST_RUN) && in_valid) begin
            rem_d       = step_next;
            digits_d    = (&digits_q) ? digits_q : digits_q + CNT_W'(1);
            out_valid_d = 1'b1;
        end

        out_d = (state_d == ST_RUN) && (rem_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mod_q       <= '0;
            rem_q       <= '0;
            digits_q    <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mod_q       <= mod_d;
            rem_q       <= rem_d;
            digits_q    <= digits_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out       = out_q;
    assign rem       = rem_q;
    assign out_valid = out_valid_q;
    assign digits    = digits_q;
    assign err       = err_q;

endmodule

`default_nettype wire
